// File: rtl/lcg_stream_if.sv
// Word stream carrying stimulus vectors into the checker.
interface lcg_stream_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/lcg_stream_checker.sv
// Checks an incoming word stream against an LCG-generated reference.
// Each vector is WORDS_PER_VEC words; the last word is compared only on
// its LAST_BITS low bits. A run covers num_cycles+1 vectors.
//
// state | meaning
// IDLE  | waiting for start, stream ignored
// RUN   | accepting and comparing words
// DONE  | run finished, results held until next start
module lcg_stream_checker #(
  parameter int WORDS_PER_VEC = 9,
  parameter int LAST_BITS     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [31:0]  seed,
  input  logic [31:0]  num_cycles,
  lcg_stream_if.slave  s,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count,
  output logic [31:0]  first_err_vec,
  output logic [3:0]   first_err_word,
  output logic [31:0]  vec_count
);

  localparam logic [31:0] LCG_MUL   = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC   = 32'h0000_3039;
  localparam logic [3:0]  LAST_IDX  = 4'(WORDS_PER_VEC - 1);
  localparam logic [31:0] LAST_MASK = (LAST_BITS >= 32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << LAST_BITS) - 32'd1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] lcg_state;
  logic [31:0] num_cycles_q;
  logic [3:0]  word_idx;
  logic        err_seen;

  logic [31:0] expected_word;
  logic [31:0] cmp_mask;
  logic        last_word;
  logic        accept;
  logic        mismatch;
  logic        final_word;
  logic [15:0] err_next;

  // Reference word, compare mask and error-count update for the current beat.
  assign expected_word = lcg_state * LCG_MUL + LCG_INC;
  assign last_word     = (word_idx == LAST_IDX);
  assign cmp_mask      = last_word ? LAST_MASK : 32'hFFFF_FFFF;
  assign accept        = s.in_valid && s.in_ready;
  assign mismatch      = accept && (|((s.in_data ^ expected_word) & cmp_mask));
  assign final_word    = accept && last_word && (vec_count == num_cycles_q);
  assign err_next      = (mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1
                                                               : err_count;

  // Run-control FSM with registered status outputs and checking datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      lcg_state      <= '0;
      num_cycles_q   <= '0;
      word_idx       <= '0;
      err_seen       <= 1'b0;
      err_count      <= '0;
      first_err_vec  <= '0;
      first_err_word <= '0;
      vec_count      <= '0;
      s.in_ready     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            lcg_state      <= seed;
            num_cycles_q   <= num_cycles;
            word_idx       <= '0;
            err_seen       <= 1'b0;
            err_count      <= '0;
            first_err_vec  <= '0;
            first_err_word <= '0;
            vec_count      <= '0;
            s.in_ready     <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            lcg_state <= expected_word;
            err_count <= err_next;
            if (mismatch && !err_seen) begin
              err_seen       <= 1'b1;
              first_err_vec  <= vec_count;
              first_err_word <= word_idx;
            end
            if (last_word) begin
              word_idx  <= '0;
              vec_count <= vec_count + 32'd1;
            end else begin
              word_idx <= word_idx + 4'd1;
            end
            if (final_word) begin
              state      <= DONE;
              s.in_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= (err_next == 16'd0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcg_stream_checker.sv
// Randomized scoreboard bench for lcg_stream_checker.
module tb_lcg_stream_checker;

  localparam int W  = 9;
  localparam int LB = 2;
  localparam logic [31:0] MUL   = 32'h41C64E6D;
  localparam logic [31:0] INC   = 32'h0000_3039;
  localparam logic [31:0] LMASK = (32'd1 << LB) - 32'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic [31:0] num_cycles = '0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_vec;
  logic [3:0]  first_err_word;
  logic [31:0] vec_count;

  lcg_stream_if sif ();

  lcg_stream_checker #(.WORDS_PER_VEC(W), .LAST_BITS(LB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_cycles(num_cycles),
    .s(sif), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_vec(first_err_vec), .first_err_word(first_err_word), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned errs;
    int unsigned fvec;
    int unsigned fword;
    int unsigned vcnt;
    bit          pass;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] words[$];
  exp_t        last_exp;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: each rising done is a finished run; compare against the oldest prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("pass", 32'(pass), 32'(e.pass));
          check("err_count", 32'(err_count), e.errs);
          check("first_err_vec", first_err_vec, e.fvec);
          check("first_err_word", 32'(first_err_word), e.fword);
          check("vec_count", vec_count, e.vcnt);
          check("busy_in_done", 32'(busy), 32'd0);
          check("ready_in_done", 32'(sif.in_ready), 32'd0);
        end
      end
      done_prev = done;
    end
  end

  // Reference model: generate the stream from the LCG rule, corrupt it per mode,
  // and tally the errors the checker must report.
  // mode 0 clean, 1 bit5 of v0 w1, 2 upper bits of v0 last word,
  // 3 bit0 of v0 last word, 4 random single-bit flips.
  task automatic build(input logic [31:0] sd, input int nc, input int mode, output exp_t e);
    logic [31:0] st, wd, msk;
    st = sd;
    words.delete();
    e.errs = 0; e.fvec = 0; e.fword = 0; e.vcnt = nc + 1;
    for (int v = 0; v <= nc; v++) begin
      for (int w = 0; w < W; w++) begin
        st = st * MUL + INC;
        wd = st;
        if (mode == 1 && v == 0 && w == 1) wd = wd ^ 32'h20;
        if (mode == 2 && v == 0 && w == W-1) wd = wd ^ 32'hFFFF_FFFC;
        if (mode == 3 && v == 0 && w == W-1) wd = wd ^ 32'h1;
        if (mode == 4 && $urandom_range(0, 7) == 0) wd = wd ^ (32'd1 << $urandom_range(0, 31));
        words.push_back(wd);
        msk = (w == W-1) ? LMASK : 32'hFFFF_FFFF;
        if (((wd ^ st) & msk) != 0) begin
          if (e.errs == 0) begin
            e.fvec = v;
            e.fword = w;
          end
          if (e.errs < 65535) e.errs++;
        end
      end
    end
    e.pass = (e.errs == 0);
  endtask

  task automatic do_start(input logic [31:0] sd, input int nc);
    @(posedge clk); #1;
    seed = sd; num_cycles = nc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seed = $urandom; num_cycles = $urandom;
  endtask

  task automatic drive(input int lim, input int gap_pct);
    int idx, cyc;
    logic acc;
    idx = 0; cyc = 0;
    while (idx < lim && cyc < lim * 4 + 100) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        sif.in_valid = 1'b0;
        sif.in_data = $urandom;
      end else begin
        sif.in_valid = 1'b1;
        sif.in_data = words[idx];
      end
      acc = sif.in_valid && sif.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    sif.in_valid = 1'b0;
    check("words_accepted", idx, lim);
  endtask

  task automatic wait_results();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check("done_reached", sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] sd, input int nc, input int mode, input int gap_pct);
    exp_t e;
    build(sd, nc, mode, e);
    last_exp = e;
    sb_q.push_back(e);
    do_start(sd, nc);
    drive(words.size(), gap_pct);
    wait_results();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(sif.in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_first_err_vec"}, first_err_vec, 32'd0);
    check({tag, "_first_err_word"}, 32'(first_err_word), 32'd0);
    check({tag, "_vec_count"}, vec_count, 32'd0);
  endtask

  initial begin
    exp_t e;
    sif.in_valid = 1'b0;
    sif.in_data = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Single clean vector from seed 0.
    run(32'h0, 0, 0, 0);
    // Bit 5 flip in vector 0, word 1.
    run(32'h0, 0, 1, 0);
    // Last word: upper bits masked out, then a flip in a compared bit.
    run(32'h0, 0, 2, 0);
    run(32'h0, 0, 3, 0);
    // Long run with valid gaps, then extra words after DONE must be ignored.
    run(32'h1234_5678, 99, 0, 30);
    for (int i = 0; i < 4; i++) begin
      sif.in_valid = 1'b1;
      sif.in_data = $urandom;
      @(negedge clk);
      check("ready_after_done", 32'(sif.in_ready), 32'd0);
    end
    sif.in_valid = 1'b0;
    check("hold_done", 32'(done), 32'd1);
    check("hold_vec_count", vec_count, last_exp.vcnt);
    check("hold_err_count", 32'(err_count), last_exp.errs);

    // Randomized runs with random corruption.
    for (int r = 0; r < 6; r++) run($urandom, $urandom_range(0, 5), 4, $urandom_range(0, 40));

    // Abort a run after 4 vectors with an asynchronous reset, then restart.
    build(32'hCAFE_0001, 9, 0, e);
    do_start(32'hCAFE_0001, 9);
    drive(4 * W, 20);
    check("mid_run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_after_abort", 32'(done), 32'd0);
    run(32'hCAFE_0001, 9, 0, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
